// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage in-order core.
// Drives stall/flush/en of the four inter-stage slices (0 IF/ID, 1 ID/EX,
// 2 EX/MEM, 3 MEM/WB) and the PC load enable. Slice priority is
// flush > stall > en, and en=0 without stall/flush loads a bubble.
// Outputs are a combinational decode of the inputs plus {fsm, cnt, redirect_pend}.
module pipe_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_ready,
    input  logic       mem_ready,
    input  logic       id_rs1_ren,
    input  logic       id_rs2_ren,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_load,
    input  logic       ex_wen,
    input  logic [4:0] ex_rd,
    input  logic       ex_mdu,
    input  logic       ex_redirect,
    input  logic       wb_trap,
    output logic       pc_en,
    output logic [3:0] slice_en,
    output logic [3:0] slice_stall,
    output logic [3:0] slice_flush,
    output logic       mdu_busy
);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MDU = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 1);

    state_t           fsm_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pend_r;

    logic             load_use_s;
    logic             mdu_wait_s;
    logic             pend_n_s;

    // Hazard detection: RAW on a load result still in EX, and MDU occupancy.
    always_comb begin
        load_use_s = ex_load && ex_wen && (ex_rd != 5'd0) &&
                     ((id_rs1_ren && (id_rs1 == ex_rd)) ||
                      (id_rs2_ren && (id_rs2 == ex_rd)));
        if (fsm_r == ST_RUN) begin
            mdu_wait_s = ex_mdu;
        end else begin
            mdu_wait_s = (cnt_r > CNT_ONE);
        end
    end

    // Priority decode of slice controls, PC enable and next redirect_pend.
    always_comb begin
        pc_en       = 1'b1;
        slice_en    = 4'b1111;
        slice_stall = 4'b0000;
        slice_flush = 4'b0000;
        pend_n_s    = pend_r;
        if (!rst) begin
            // Reset looks like RUN with every input low and no fetch result.
            pc_en    = 1'b0;
            slice_en = 4'b1110;
            pend_n_s = 1'b0;
        end else if (wb_trap) begin
            slice_flush = 4'b1111;
            pend_n_s    = 1'b0;
        end else if (!mem_ready) begin
            // Redirect is masked here; EX holds so it is seen again later.
            slice_stall = 4'b0111;
            slice_en    = 4'b0111;
            pc_en       = 1'b0;
        end else if (mdu_wait_s) begin
            slice_stall = 4'b0011;
            slice_en    = 4'b1011;
            pc_en       = 1'b0;
        end else if (ex_redirect) begin
            // A fetch still outstanding belongs to the wrong path.
            slice_flush = 4'b0011;
            pend_n_s    = pend_r || !if_ready;
        end else if (pend_r && if_ready) begin
            // Stale fetch arrived: drop it, PC now advances from the target.
            slice_flush = 4'b0001;
            pend_n_s    = 1'b0;
        end else if (load_use_s) begin
            slice_stall = 4'b0001;
            slice_flush = 4'b0010;
            pc_en       = 1'b0;
        end else if (!if_ready) begin
            slice_en = 4'b1110;
            pc_en    = 1'b0;
        end else begin
            pc_en = 1'b1;
        end
    end

    assign mdu_busy = rst && (fsm_r == ST_MDU);

    // MDU sequencing FSM with countdown, plus the pending-redirect flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_r  <= ST_RUN;
            cnt_r  <= CNT_ZERO;
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_n_s;
            if (wb_trap) begin
                fsm_r <= ST_RUN;
                cnt_r <= CNT_ZERO;
            end else begin
                case (fsm_r)
                    ST_RUN: begin
                        if (ex_mdu) begin
                            fsm_r <= ST_MDU;
                            cnt_r <= CNT_INIT;
                        end else begin
                            fsm_r <= ST_RUN;
                            cnt_r <= CNT_ZERO;
                        end
                    end
                    ST_MDU: begin
                        if (cnt_r > CNT_ONE) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end else if (mem_ready) begin
                            fsm_r <= ST_RUN;
                            cnt_r <= CNT_ZERO;
                        end else begin
                            cnt_r <= CNT_ONE;
                        end
                    end
                    default: begin
                        fsm_r <= ST_RUN;
                        cnt_r <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios followed by randomized cycles, each cycle
// compared against a behavioural model that tracks how long the current
// mul/div op has occupied EX and whether a stale fetch is still owed.
module tb_pipe_ctrl;

    localparam int MDU_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_ready, mem_ready, id_rs1_ren, id_rs2_ren;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_load, ex_wen, ex_mdu, ex_redirect, wb_trap;
    logic       pc_en, mdu_busy;
    logic [3:0] slice_en, slice_stall, slice_flush;

    int errors = 0;
    int checks = 0;

    // Model state: cycles the MDU op has spent in EX so far (0 = none), pending stale fetch.
    int   m_age  = 0;
    logic m_pend = 1'b0;

    pipe_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .if_ready(if_ready), .mem_ready(mem_ready),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_load(ex_load), .ex_wen(ex_wen), .ex_rd(ex_rd),
        .ex_mdu(ex_mdu), .ex_redirect(ex_redirect), .wb_trap(wb_trap),
        .pc_en(pc_en), .slice_en(slice_en), .slice_stall(slice_stall),
        .slice_flush(slice_flush), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        if_ready = 1'b1; mem_ready = 1'b1;
        id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        ex_load = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0;
        ex_mdu = 1'b0; ex_redirect = 1'b0; wb_trap = 1'b0;
    endtask

    // Check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick(input string tag);
        logic       e_pc, e_busy, n_pend, lu, wt;
        logic [3:0] e_en, e_st, e_fl;
        int         n_age;
        @(negedge clk);
        e_pc = 1'b1; e_en = 4'b1111; e_st = 4'b0000; e_fl = 4'b0000;
        e_busy = (m_age != 0);
        n_pend = m_pend;
        lu = ex_load && ex_wen && (ex_rd != 5'd0) &&
             ((id_rs1_ren && id_rs1 == ex_rd) || (id_rs2_ren && id_rs2 == ex_rd));
        // An op needs MDU_LAT cycles in EX; it is held for the first MDU_LAT-1.
        wt = (m_age == 0) ? ex_mdu : (m_age < MDU_LAT - 1);
        if (m_age == 0)                n_age = ex_mdu ? 1 : 0;
        else if (m_age < MDU_LAT - 1)  n_age = m_age + 1;
        else                           n_age = mem_ready ? 0 : m_age;
        if (!rst) begin
            e_pc = 1'b0; e_en = 4'b1110; e_busy = 1'b0; n_pend = 1'b0; n_age = 0;
        end else if (wb_trap) begin
            e_fl = 4'b1111; n_pend = 1'b0; n_age = 0;
        end else if (!mem_ready) begin
            e_st = 4'b0111; e_en = 4'b0111; e_pc = 1'b0;
        end else if (wt) begin
            e_st = 4'b0011; e_en = 4'b1011; e_pc = 1'b0;
        end else if (ex_redirect) begin
            e_fl = 4'b0011; n_pend = m_pend | ~if_ready;
        end else if (m_pend && if_ready) begin
            e_fl = 4'b0001; n_pend = 1'b0;
        end else if (lu) begin
            e_st = 4'b0001; e_fl = 4'b0010; e_pc = 1'b0;
        end else if (!if_ready) begin
            e_en = 4'b1110; e_pc = 1'b0;
        end
        checks++;
        assert (pc_en === e_pc) else begin
            errors++; $error("FAIL %s pc_en: got %b expected %b", tag, pc_en, e_pc);
        end
        checks++;
        assert (slice_en === e_en) else begin
            errors++; $error("FAIL %s slice_en: got %b expected %b", tag, slice_en, e_en);
        end
        checks++;
        assert (slice_stall === e_st) else begin
            errors++; $error("FAIL %s slice_stall: got %b expected %b", tag, slice_stall, e_st);
        end
        checks++;
        assert (slice_flush === e_fl) else begin
            errors++; $error("FAIL %s slice_flush: got %b expected %b", tag, slice_flush, e_fl);
        end
        checks++;
        assert (mdu_busy === e_busy) else begin
            errors++; $error("FAIL %s mdu_busy: got %b expected %b", tag, mdu_busy, e_busy);
        end
        @(posedge clk);
        if (rst) begin
            m_age = n_age; m_pend = n_pend;
        end else begin
            m_age = 0; m_pend = 1'b0;
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        tick("reset0");
        tick("reset1");
        rst = 1'b1;
        tick("idle");

        // Single MDU op, memory ready throughout.
        ex_mdu = 1'b1;
        tick("mdu_c1"); tick("mdu_c2"); tick("mdu_c3"); tick("mdu_c4");
        ex_mdu = 1'b0;
        tick("mdu_c5");

        // Load-use on rs2, then the same with rd=x0.
        ex_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5; id_rs2_ren = 1'b1; id_rs2 = 5'd5;
        tick("lu_hit");
        ex_rd = 5'd0;
        tick("lu_x0");
        clear_inputs();

        // Redirect while the fetch is outstanding.
        ex_redirect = 1'b1; if_ready = 1'b0;
        tick("redir");
        ex_redirect = 1'b0;
        tick("pend_w1"); tick("pend_w2");
        if_ready = 1'b1;
        tick("pend_drop");
        tick("pend_after");

        // Memory wait masks a redirect.
        mem_ready = 1'b0; ex_redirect = 1'b1;
        tick("mem_m1"); tick("mem_m2"); tick("mem_m3");
        mem_ready = 1'b1;
        tick("mem_go");
        ex_redirect = 1'b0;

        // Trap arriving mid-MDU with a redirect pending.
        ex_redirect = 1'b1; if_ready = 1'b0;
        tick("tr_redir");
        ex_redirect = 1'b0; ex_mdu = 1'b1;
        tick("tr_mdu1"); tick("tr_mdu2");
        wb_trap = 1'b1;
        tick("tr_trap");
        clear_inputs();
        tick("tr_after");

        // Asynchronous reset in the middle of an MDU op.
        ex_mdu = 1'b1;
        tick("rm_c1"); tick("rm_c2");
        rst = 1'b0;
        tick("rm_rst");
        rst = 1'b1; ex_mdu = 1'b0;
        tick("rm_rel");

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 63) != 0);
            if_ready    = ($urandom_range(0, 3) != 0);
            mem_ready   = ($urandom_range(0, 4) != 0);
            id_rs1_ren  = 1'($urandom_range(0, 1));
            id_rs2_ren  = 1'($urandom_range(0, 1));
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_load     = 1'($urandom_range(0, 1));
            ex_wen      = ($urandom_range(0, 3) != 0);
            ex_rd       = 5'($urandom_range(0, 3));
            ex_mdu      = ($urandom_range(0, 7) == 0);
            ex_redirect = ($urandom_range(0, 7) == 0);
            wb_trap     = ($urandom_range(0, 31) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
